// File: rtl/zoom_coef_gen.sv
// Horizontal bilinear coefficient generator for the ZOOM scaler.
// Walks a u12.16 source position across one output line and emits, per output
// pixel, the two neighbouring source indices plus a 7-bit weight pair that
// always sums to 127. All outputs come straight from registers.
module zoom_coef_gen #(
  parameter int unsigned IW = 12,
  parameter int unsigned FW = 16,
  parameter int unsigned SW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] src_w,
  input  logic [IW-1:0] dst_w,
  input  logic [SW-1:0] step,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [IW-1:0] o_idx0,
  output logic [IW-1:0] o_idx1,
  output logic [6:0]    o_w0,
  output logic [6:0]    o_w1,
  output logic          o_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned AW = IW + FW;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [IW-1:0] src_max_q;
  logic [IW-1:0] dst_w_q;
  logic [SW-1:0] step_q;
  logic [AW-1:0] acc_q;
  logic [IW-1:0] cnt_q;

  logic          valid_q;
  logic [IW-1:0] idx0_q;
  logic [IW-1:0] idx1_q;
  logic [6:0]    w0_q;
  logic [6:0]    w1_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;

  logic          start_ok;
  logic          beat;
  logic [IW-1:0] src_max_d;
  logic [IW-1:0] smax_sel;
  logic [AW-1:0] acc_d;
  logic [IW-1:0] cnt_d;
  logic [IW-1:0] ip;
  logic [IW:0]   ip_p1;
  logic [6:0]    frac;
  logic [IW-1:0] idx0_d;
  logic [IW-1:0] idx1_d;
  logic [6:0]    w0_d;
  logic [6:0]    w1_d;
  logic          last_d;

  // Coefficient set for the position the output register loads next: position 0
  // on an accepted start, otherwise the current position advanced by one step.
  always_comb begin
    start_ok  = (state_q == StIdle) && start;
    beat      = (state_q == StRun) && valid_q && o_ready;
    // A zero source width behaves like a single-pixel line.
    src_max_d = (src_w == '0) ? '0 : src_w - IW'(1);
    smax_sel  = start_ok ? src_max_d : src_max_q;
    acc_d     = start_ok ? '0 : acc_q + AW'(step_q);
    cnt_d     = start_ok ? '0 : cnt_q + IW'(1);
    ip        = acc_d[AW-1:FW];
    frac      = acc_d[FW-1 -: 7];
    // One extra bit so ip = max does not wrap to 0 before clamping.
    ip_p1     = {1'b0, ip} + (IW+1)'(1);
    idx0_d    = (ip > smax_sel) ? smax_sel : ip;
    idx1_d    = (ip_p1 > {1'b0, smax_sel}) ? smax_sel : ip_p1[IW-1:0];
    w1_d      = frac;
    w0_d      = 7'd127 - frac;
    last_d    = start_ok ? (dst_w == IW'(1)) : (cnt_d == dst_w_q - IW'(1));
  end

  // Line FSM with configuration capture, position accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      src_max_q <= '0;
      dst_w_q   <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      idx0_q    <= '0;
      idx1_q    <= '0;
      w0_q      <= '0;
      w1_q      <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            src_max_q <= src_max_d;
            dst_w_q   <= dst_w;
            step_q    <= step;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= 1'b1;
            if (dst_w != '0) begin
              state_q <= StRun;
              valid_q <= 1'b1;
              idx0_q  <= idx0_d;
              idx1_q  <= idx1_d;
              w0_q    <= w0_d;
              w1_q    <= w1_d;
              last_q  <= last_d;
            end else begin
              // Empty line: skip straight to the completion pulse.
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (beat) begin
            if (last_q) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              acc_q  <= acc_d;
              cnt_q  <= cnt_d;
              idx0_q <= idx0_d;
              idx1_q <= idx1_d;
              w0_q   <= w0_d;
              w1_q   <= w1_d;
              last_q <= last_d;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_idx0  = idx0_q;
  assign o_idx1  = idx1_q;
  assign o_w0    = w0_q;
  assign o_w1    = w1_q;
  assign o_last  = last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_zoom_coef_gen.sv
// Self-checking bench for zoom_coef_gen: directed vector table, hand-written
// corner sequences and randomized lines against an arithmetic reference model.
module tb_zoom_coef_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] src_w;
  logic [11:0] dst_w;
  logic [19:0] step;
  logic        o_valid;
  logic        o_ready;
  logic [11:0] o_idx0;
  logic [11:0] o_idx1;
  logic [6:0]  o_w0;
  logic [6:0]  o_w1;
  logic        o_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  zoom_coef_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_w   (src_w),
    .dst_w   (dst_w),
    .step    (step),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_idx0  (o_idx0),
    .o_idx1  (o_idx1),
    .o_w0    (o_w0),
    .o_w1    (o_w1),
    .o_last  (o_last),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [11:0] idx0;
    logic [11:0] idx1;
    logic [6:0]  w0;
    logic [6:0]  w1;
    logic        last;
  } set_t;

  typedef struct {
    int unsigned src;
    int unsigned dst;
    int unsigned stp;
    set_t        exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  set_t got_q[$];
  set_t exp_q[$];
  int   done_c;
  int   stall_c;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pack_set(input set_t s);
    return {s.idx0, s.idx1, s.w0, s.w1, s.last, 1'b0};
  endfunction

  function automatic set_t mk(input int unsigned i0, input int unsigned i1,
                              input int unsigned a, input int unsigned b, input bit l);
    set_t s;
    s.idx0 = 12'(i0);
    s.idx1 = 12'(i1);
    s.w0   = 7'(a);
    s.w1   = 7'(b);
    s.last = l;
    return s;
  endfunction

  // Bilinear position of output pixel k is k*step in u12.16, wrapping at 28 bits.
  function automatic set_t model_set(input int unsigned src, input int unsigned k,
                                     input int unsigned stp, input int unsigned dst);
    longint unsigned acc, ip, frac, smax;
    set_t s;
    acc  = (longint'(k) * longint'(stp)) % (64'd1 << 28);
    ip   = acc / 65536;
    frac = (acc / 512) % 128;
    smax = (src == 0) ? 0 : src - 1;
    s.idx0 = 12'((ip < smax) ? ip : smax);
    s.idx1 = 12'((ip + 1 < smax) ? ip + 1 : smax);
    s.w1   = 7'(frac);
    s.w0   = 7'(127 - frac);
    s.last = (k == dst - 1);
    return s;
  endfunction

  task automatic build_model(input int unsigned src, input int unsigned dst,
                             input int unsigned stp);
    exp_q.delete();
    for (int unsigned k = 0; k < dst; k++) exp_q.push_back(model_set(src, k, stp, dst));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low on cycles 2-4.
  // inj_cyc: cycle at which a stray start (dst_w=1) is pulsed, 0 for none.
  task automatic run_line(input int unsigned src, input int unsigned dst,
                          input int unsigned stp, input int mode, input int inj_cyc);
    logic        rdy;
    logic        prev_hold;
    logic [39:0] prev_vec;
    got_q.delete();
    stall_c   = 0;
    done_c    = -1;
    prev_hold = 1'b0;
    prev_vec  = '0;
    src_w = 12'(src);
    dst_w = 12'(dst);
    step  = 20'(stp);
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("valid_after_start", 64'(o_valid), 64'(dst != 0));
    for (int c = 1; c <= 5000; c++) begin
      if (c == inj_cyc) begin
        start = 1'b1;
        dst_w = 12'd1;
        src_w = 12'd5;
        step  = 20'h12345;
      end else begin
        start = 1'b0;
      end
      if (prev_hold)
        chk("hold_stable", 64'({o_valid, o_idx0, o_idx1, o_w0, o_w1, o_last}), 64'(prev_vec));
      if (done) begin
        done_c = c;
        chk("done_no_valid", 64'(o_valid), 64'd0);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(c >= 2 && c <= 4);
      endcase
      o_ready = rdy;
      if (o_valid && rdy) got_q.push_back(mk(o_idx0, o_idx1, o_w0, o_w1, o_last));
      if (o_valid && !rdy) stall_c++;
      prev_hold = o_valid && !rdy;
      prev_vec  = {o_valid, o_idx0, o_idx1, o_w0, o_w1, o_last};
      step_cyc();
    end
    step_cyc();
    start = 1'b0;
    if (done_c < 0) chk("done_timeout", 64'd0, 64'd1);
    else chk("done_cycle", 64'(done_c), 64'(dst + stall_c + 1));
    chk("idle_after_done", 64'({busy, done, o_valid}), 64'd0);
    o_ready = 1'b1;
  endtask

  task automatic cmp_sets(input string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_set"}, 64'(pack_set(got_q[i])), 64'(pack_set(exp_q[i])));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int unsigned src, dst, stp;

    // Upscale x2 then identity, one entry per expected set.
    vecs[0]  = '{2, 4, 32'h08000, mk(0, 1, 127, 0, 0)};
    vecs[1]  = '{2, 4, 32'h08000, mk(0, 1, 63, 64, 0)};
    vecs[2]  = '{2, 4, 32'h08000, mk(1, 1, 127, 0, 0)};
    vecs[3]  = '{2, 4, 32'h08000, mk(1, 1, 63, 64, 1)};
    for (int k = 0; k < 8; k++)
      vecs[4+k] = '{8, 8, 32'h10000, mk(k, (k + 1 < 7) ? k + 1 : 7, 127, 0, k == 7)};

    rst = 1'b1; start = 1'b0; src_w = '0; dst_w = '0; step = '0; o_ready = 1'b1;
    repeat (3) step_cyc();
    chk("reset_outputs", 64'({o_valid, o_idx0, o_idx1, o_w0, o_w1, o_last, busy, done}), 64'd0);
    rst = 1'b0;
    step_cyc();

    base = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || vecs[i].src != vecs[i-1].src || vecs[i].dst != vecs[i-1].dst ||
          vecs[i].stp != vecs[i-1].stp) begin
        run_line(vecs[i].src, vecs[i].dst, vecs[i].stp, 0, 0);
        chk("table_count", 64'(got_q.size()), 64'(vecs[i].dst));
        base = i;
      end
      if (i - base < got_q.size())
        chk("table_set", 64'(pack_set(got_q[i-base])), 64'(pack_set(vecs[i].exp)));
    end

    // Backpressure: second set held for three cycles, done slips by three.
    build_model(2, 4, 32'h08000);
    run_line(2, 4, 32'h08000, 2, 0);
    chk("bp_stalls", 64'(stall_c), 64'd3);
    chk("bp_done_cycle", 64'(done_c), 64'd8);
    cmp_sets("bp");

    // Stray start during RUN is ignored.
    run_line(2, 4, 32'h08000, 0, 2);
    cmp_sets("start_in_run");

    // Stray start during DONE is dropped (run_line pulses it at the done cycle).
    run_line(2, 4, 32'h08000, 0, 5);
    cmp_sets("start_in_done");

    // Zero-width line.
    build_model(5, 0, 32'h10000);
    run_line(5, 0, 32'h10000, 0, 0);
    chk("zero_done_cycle", 64'(done_c), 64'd1);
    cmp_sets("zero");

    // src_w = 0 behaves as 1.
    build_model(0, 6, 32'h18000);
    run_line(0, 6, 32'h18000, 1, 0);
    cmp_sets("src_zero");

    // Far right edge of a maximum-width source, with accumulator wrap.
    build_model(4095, 300, 32'hFFFFF);
    run_line(4095, 300, 32'hFFFFF, 0, 0);
    cmp_sets("wide");

    // Reset mid-line, then a clean restart.
    src_w = 12'd2; dst_w = 12'd4; step = 20'h08000; o_ready = 1'b1; start = 1'b1;
    step_cyc();
    start = 1'b0;
    step_cyc();
    step_cyc();
    rst = 1'b1;
    step_cyc();
    chk("midline_reset", 64'({o_valid, o_idx0, o_idx1, o_w0, o_w1, o_last, busy, done}), 64'd0);
    rst = 1'b0;
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    chk("restart_first", 64'({o_valid, o_idx0, o_w0, o_w1}), 64'({1'b1, 12'd0, 7'd127, 7'd0}));
    begin
      int t = 0;
      while (!done && t < 20) begin
        step_cyc();
        t++;
      end
      chk("restart_done_seen", 64'(done), 64'd1);
    end
    step_cyc();
    step_cyc();

    // Randomized lines with random backpressure.
    for (int n = 0; n < 25; n++) begin
      src = $urandom_range(0, 20);
      dst = $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 1) stp = $urandom_range(0, 32'h20000);
      else stp = $urandom_range(0, 32'hFFFFF);
      build_model(src, dst, stp);
      run_line(src, dst, stp, 1, 0);
      cmp_sets("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zoom_coef_gen.md
# zoom_coef_gen

Horizontal bilinear coefficient generator for the ZOOM scaler. For each output pixel of a line, it produces the two source-pixel indices and the pair of 7-bit unsigned interpolation weights. The weights feed the 7x8 weight-by-pixel multipliers downstream. The block sits between line control, which issues one `start` per output line, and the line-buffer read and multiply stage, which consumes one coefficient set per accepted beat.

## Interface
- `IW`, 12, width of source/destination pixel counts and indices
- `FW`, 16, fractional bits of the step and of the position accumulator
- `SW`, 20, width of `step` (4 integer bits + `FW` fraction)

- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a line; honoured only in IDLE
- `src_w`  in  IW  source line width in pixels; sampled on accepted `start`
- `dst_w`  in  IW  output pixels to generate; sampled on accepted `start`
- `step`  in  SW  source advance per output pixel (u4.16); sampled on accepted `start`
- `o_valid`  out  1  coefficient set valid
- `o_ready`  in  1  downstream accepts the set when `o_valid && o_ready`
- `o_idx0`  out  IW  left source index
- `o_idx1`  out  IW  right source index
- `o_w0`  out  7  weight for `o_idx0`
- `o_w1`  out  7  weight for `o_idx1`
- `o_last`  out  1  marks the last set of the line
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse when the line completes

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE -> RUN on `start` when `dst_w != 0`.
  - IDLE -> DONE on `start` when `dst_w == 0`. No sets are emitted.
  - RUN -> DONE when the beat with `o_last` is accepted.
  - DONE -> IDLE after one cycle. `done` is high during that cycle.
- **Start while busy:** `start` in RUN or DONE is ignored. The captured configuration stays unchanged.
- **Accumulator:** `acc`, width IW+FW = 28 bits, unsigned. It is cleared on accepted `start`, and `acc += step` on each accepted beat. The output counter `cnt` goes 0..dst_w-1.
- **Per-set arithmetic:**
  - `ip = acc[27:16]`
  - `frac = acc[15:9]`, truncated with no rounding
  - `o_idx0 = min(ip, src_w-1)`
  - `o_idx1 = min(ip+1, src_w-1)`
  - `o_w1 = frac`
  - `o_w0 = 7'd127 - frac`
- **Weight normalisation:** the weights always sum to 127. The downstream stage divides by 128 (`>>7`), so the datapath gain is 127/128.
- **Edge clamping:** if `ip >= src_w-1`, both indices equal `src_w-1`. The weights are still emitted unmodified.
- **Source width corner cases:** `src_w == 0` is treated as 1, so all indices are 0.
- **`o_last`:** high when `cnt == dst_w-1`.
- **Output register:** all outputs are registered. When `o_valid && !o_ready`, every `o_*` field holds stable and neither `acc` nor `cnt` advances.
- **Reset:** `rst` at any time, including mid-line, returns the block to IDLE on the next edge and discards any line in progress. Reset values: `o_valid`, `o_idx0`, `o_idx1`, `o_w0`, `o_w1`, `o_last`, `busy`, `done` all 0.

## Timing
- **Start to first set:** `start` accepted at edge N gives `busy = 1` and `o_valid = 1` with set 0 from edge N+1.
- **Throughput:** one set per cycle while `o_ready = 1`, so a line takes `dst_w` cycles with no bubbles between sets.
- **End of line:** after the `o_last` beat is accepted at edge M, `o_valid = 0` and `done = 1` for the cycle following M, and `busy` drops one cycle later.
- **Earliest next start:** IDLE is reached at M+2.
- **Zero-width line:** a `dst_w = 0` start at edge N gives `done = 1` for the cycle following N, and the block is back in IDLE at N+2.
- **Back-to-back lines:** a `start` arriving during DONE is dropped. Line control must wait for `done`.
- **Downstream pairing:** downstream registers its multiply one cycle after acceptance. This block adds no alignment delay of its own.

## Test plan
- **Upscale x2:** `src_w=2`, `dst_w=4`, `step=0x08000`, `o_ready=1` -> the following sets, then `done` one cycle later:
  - (idx0, idx1, w0, w1) = (0,1,127,0)
  - (0,1,63,64)
  - (1,1,127,0), with both indices clamped
  - (1,1,63,64), with `o_last`
- **Identity:** `src_w=dst_w=8`, `step=0x10000` -> `idx0 = 0..7`, `w1 = 0` throughout, `idx1 = min(k+1, 7)`, `o_last` on k=7.
- **Backpressure:** the x2 case with `o_ready` low on cycles 2-4 -> the second set is held stable for 3 cycles, no set is lost or duplicated, and `done` slips by 3 cycles.
- **Ignored starts and zero width:**
  - A second `start` during RUN with `dst_w=1` -> ignored, and the original 4-set sequence completes.
  - `start` with `dst_w=0` -> no `o_valid`, and `done` pulses one cycle later.
- **Reset mid-line:** `rst` asserted after set 1 -> all outputs 0 next cycle. A fresh `start` then restarts at idx0=0, w1=0.
